dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder on the far end of the pipeline's MEM-stage load/store interface.
- Replaces the single-cycle data memory with a handshaked, multi-cycle memory.
- Accepts one word read or write at a time, inserts a configurable number of wait states, and returns read data with an error flag.
- Drives a stall to the pipeline while a request is outstanding.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 1024, number of stored words; power of two.
- WAIT_CYCLES, 2, wait states between acceptance and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset.
- req_valid  input  1  request present; held by requester until the response cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- req_ready  output  1  responder can accept this cycle.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range access; valid with resp_valid.
- stall  output  1  freeze IF/ID/EX/MEM stages.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; wait counter to 0.
  - All storage words cleared to 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 after the edge.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid, latch write, addr and wdata. Load counter with WAIT_CYCLES-1.
    - Next state is WAIT, or RESP directly if WAIT_CYCLES==0.
  - WAIT:
    - req_ready=0. Counter decrements each cycle.
    - When the counter reaches 0, perform the access and go to RESP.
  - RESP:
    - resp_valid=1 for exactly one cycle; req_ready=0.
    - Next state is IDLE unconditionally.
- Access:
  - Storage index is addr[log2(DEPTH_WORDS)+1:2].
  - Error if addr[1:0]!=0 or addr >= 4*DEPTH_WORDS. On error: no write, rdata=0, err=1.
  - Store: the write commits on the clock edge that enters RESP, using the latched data.
  - Load: resp_rdata is registered; it holds the word read at that same edge.
- Latency: response arrives WAIT_CYCLES+1 cycles after acceptance.
  - Accept in cycle N → resp_valid in cycle N+WAIT_CYCLES+1.
- Stall:
  - stall = req_valid & ~resp_valid (combinational).
  - It is low in the RESP cycle so the pipeline advances exactly once per access.
  - Requester inputs are ignored outside IDLE; changes mid-flight have no effect.
- Back-to-back requests:
  - A new request presented in the cycle after RESP is accepted in IDLE.
  - Minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
- Reset mid-operation: the in-flight access is aborted and a pending store is never committed.
- resp_rdata and resp_err keep their last values while resp_valid=0.

Optional Feature:
- Macro: DM_ACCESS_COUNT_EN.
- When defined:
  - Adds outputs load_count[31:0] and store_count[31:0].
  - Each increments on the RESP edge of a non-error load or store, respectively.
  - Both wrap from 0xFFFFFFFF to 0. Both clear on reset.
- When undefined: these ports and their counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dm_pkg:
  - State encoding IDLE/WAIT/RESP (2-bit enum).
  - WORD_BYTES=4.
  - Address-offset constant 2.
- Sub-module dm_storage: word array with synchronous write, registered read and synchronous clear.
- Handshake FSM, counter and error check stay in dm_responder.

Test Plan:
- Reset with rst=0 for 2 cycles → req_ready=1, resp_valid=0, stall=0; a load of 0x10 returns 0 with err=0.
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x40 accepted in cycle N → resp_valid in N+3, stall high N..N+2 and low at N+3; load 0x40 then returns 0xDEADBEEF.
- Misaligned store to 0x42 → resp_err=1, rdata=0; a following load of 0x40 returns the prior value unchanged.
- Out-of-range load at 0x1000 with DEPTH_WORDS=1024 → resp_err=1, rdata=0.
- Store to 0x80 with rst asserted in the WAIT cycle → after reset, load 0x80 returns 0 and no resp_valid was emitted for the aborted store.
- WAIT_CYCLES=0, back-to-back loads of 0x0 and 0x4 → each response arrives 1 cycle after acceptance, acceptances 2 cycles apart. With DM_ACCESS_COUNT_EN defined, load_count=2 afterwards.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: state encoding and address constants shared by the data-memory responder.
package dm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} dm_state_e;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_OFS = 2;
endpackage

// File: rtl/dm_storage.sv
// dm_storage: word array with synchronous write, registered read and synchronous clear.
module dm_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_WIDTH = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  rd_clr_i,
    input  logic [IDX_WIDTH-1:0]  idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] words [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [DATA_WIDTH-1:0] w_q;
        always_ff @(posedge clk) begin
            if (!rst) w_q <= '0;
            else if (wr_en_i && idx_i == IDX_WIDTH'(g)) w_q <= wdata_i;
        end
        assign words[g] = w_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) rdata_q <= '0;
        else if (rd_clr_i) rdata_q <= '0;
        else if (rd_en_i) rdata_q <= words[idx_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/dm_responder.sv
// dm_responder: handshaked multi-cycle data memory with wait states, error flag and pipeline stall.
// Defining DM_ACCESS_COUNT_EN adds load_count/store_count outputs.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  stall
`ifdef DM_ACCESS_COUNT_EN
    ,
    output logic [31:0]           load_count,
    output logic [31:0]           store_count
`endif
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(WORD_BYTES * DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dm_state_e             state_q;
    logic [3:0]            cnt_q;
    logic                  write_q, ready_q, resp_valid_q, resp_err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  direct, access, acc_write, acc_err;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    // With no wait states the access happens on the accepting edge, straight from the request inputs.
    assign direct    = (WAIT_CYCLES == 0) && state_q == IDLE && req_valid;
    assign access    = direct || (state_q == WAIT && cnt_q == 4'd0);
    assign acc_write = direct ? req_write : write_q;
    assign acc_addr  = direct ? req_addr : addr_q;
    assign acc_wdata = direct ? req_wdata : wdata_q;
    assign acc_err   = (acc_addr[ADDR_OFS-1:0] != '0) || ({1'b0, acc_addr} >= LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (access) resp_err_q <= acc_err;
            case (state_q)
                IDLE: if (req_valid) begin
                    write_q      <= req_write;
                    addr_q       <= req_addr;
                    wdata_q      <= req_wdata;
                    cnt_q        <= CNT_INIT;
                    ready_q      <= 1'b0;
                    state_q      <= direct ? RESP : WAIT;
                    resp_valid_q <= direct;
                end
                WAIT: if (access) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    dm_storage #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_WORDS(DEPTH_WORDS), .IDX_WIDTH(IW)) u_storage (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (access && acc_write && !acc_err),
        .rd_en_i  (access && !acc_write && !acc_err),
        .rd_clr_i (access && (acc_write || acc_err)),
        .idx_i    (acc_addr[IW+1:ADDR_OFS]),
        .wdata_i  (acc_wdata),
        .rdata_o  (resp_rdata)
    );

`ifdef DM_ACCESS_COUNT_EN
    logic [31:0] load_cnt_q, store_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else if (access && !acc_err) begin
            if (acc_write) store_cnt_q <= store_cnt_q + 32'd1;
            else load_cnt_q <= load_cnt_q + 32'd1;
        end
    end
    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
`endif

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign stall      = req_valid && !resp_valid_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed vectors against a WAIT_CYCLES=2 instance (index 0) and a WAIT_CYCLES=0 instance (index 1).
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid [2];
    logic        req_write [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        req_ready [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err [2];
    logic        stall [2];
`ifdef DM_ACCESS_COUNT_EN
    logic [31:0] load_count [2];
    logic [31:0] store_count [2];
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_responder #(.WAIT_CYCLES(g == 0 ? 2 : 0)) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .stall      (stall[g])
`ifdef DM_ACCESS_COUNT_EN
            ,
            .load_count (load_count[g]),
            .store_count(store_count[g])
`endif
        );
    end

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        er;
    } vec_t;
    vec_t v [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Presents one request at a falling edge, holds it until the response, drops it one cycle later.
    task automatic acc(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e_rd, input logic e_er, input int e_lat, input string nm);
        int lat = -1;
        req_valid[u] = 1'b1;
        req_write[u] = w;
        req_addr[u]  = a;
        req_wdata[u] = d;
        #1 chk({nm, " ready"}, 32'(req_ready[u]), 32'd1);
        for (int k = 0; k <= e_lat + 4 && lat < 0; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (resp_valid[u]) begin
                lat = k;
                chk({nm, " stall_resp"}, 32'(stall[u]), 32'd0);
                chk({nm, " rdata"}, resp_rdata[u], e_rd);
                chk({nm, " err"}, 32'(resp_err[u]), 32'(e_er));
            end else begin
                chk({nm, " stall_wait"}, 32'(stall[u]), 32'd1);
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(e_lat));
        @(negedge clk);
        req_valid[u] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        time  t0;
        v[0]  = '{1'b0, 32'h10,   32'h0,        32'h0,        1'b0};
        v[1]  = '{1'b1, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0};
        v[2]  = '{1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0};
        v[3]  = '{1'b1, 32'h42,   32'h12345678, 32'h0,        1'b1};
        v[4]  = '{1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0};
        v[5]  = '{1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
        v[6]  = '{1'b1, 32'hFFC,  32'hA5A5A5A5, 32'h0,        1'b0};
        v[7]  = '{1'b0, 32'hFFC,  32'h0,        32'hA5A5A5A5, 1'b0};
        v[8]  = '{1'b0, 32'h1003, 32'h0,        32'h0,        1'b1};
        v[9]  = '{1'b1, 32'h0,    32'h11111111, 32'h0,        1'b0};
        v[10] = '{1'b0, 32'h0,    32'h0,        32'h11111111, 1'b0};
        v[11] = '{1'b0, 32'h402,  32'h0,        32'h0,        1'b1};
        v[12] = '{1'b0, 32'h4,    32'h0,        32'h0,        1'b0};
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst ready", 32'(req_ready[0]), 32'd1);
        chk("rst resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst stall", 32'(stall[0]), 32'd0);
        chk("rst rdata", resp_rdata[0], 32'h0);
        chk("rst err", 32'(resp_err[0]), 32'd0);
        chk("rst ready0", 32'(req_ready[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            acc(0, v[i].w, v[i].a, v[i].d, v[i].rd, v[i].er, 3, $sformatf("v%0d", i));
            #1;
            chk($sformatf("v%0d idle_valid", i), 32'(resp_valid[0]), 32'd0);
            chk($sformatf("v%0d hold_rdata", i), resp_rdata[0], v[i].rd);
            chk($sformatf("v%0d hold_err", i), 32'(resp_err[0]), 32'(v[i].er));
        end
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h80;
        req_wdata[0] = 32'hCAFEF00D;
        @(negedge clk);
        #1 chk("abort ready_in_wait", 32'(req_ready[0]), 32'd0);
        rst = 1'b0;
        req_valid[0] = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 seen = seen | resp_valid[0];
        end
        chk("abort no_resp", 32'(seen), 32'd0);
        rst = 1'b1;
        chk("abort ready", 32'(req_ready[0]), 32'd1);
        acc(0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 3, "abort load80");
        acc(0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 3, "cleared load40");
        acc(1, 1'b1, 32'h0, 32'h1234, 32'h0, 1'b0, 1, "w0 st0");
        acc(1, 1'b1, 32'h4, 32'h5678, 32'h0, 1'b0, 1, "w0 st4");
        t0 = $time;
        acc(1, 1'b0, 32'h0, 32'h0, 32'h1234, 1'b0, 1, "w0 ld0");
        chk("w0 spacing", 32'($time - t0), 32'd20);
        acc(1, 1'b0, 32'h4, 32'h0, 32'h5678, 1'b0, 1, "w0 ld4");
`ifdef DM_ACCESS_COUNT_EN
        chk("w0 load_count", load_count[1], 32'd2);
        chk("w0 store_count", store_count[1], 32'd2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
